vend_ctrl: RTL and testbench
============================

Name: vend_ctrl

Overview:
- Transaction controller for a dual-slot coin vending machine with multiple products.
- Arbitrates two coin acceptors onto one credit accumulator and checks each product selection against price and stock.
- Sequences the dispense handshake to the motor driver, then returns change one unit per handshake.
- Sits between the coin acceptors and keypad on one side and the dispense and change-return actuators on the other.

Parameters:
- PRICE, 3: product price in coin units.
- MAX_CREDIT, 7: credit ceiling in units; must fit in CW bits.
- CW, 3: credit register width.
- NPROD, 4: number of products; sel is clog2(NPROD) bits, 2 bits at default.
- STOCK_INIT, 4: per-product stock after reset or restock.
- SW, 3: stock counter width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- coin_a  in  2  slot A coin code: 00 none, 01 one unit, 10 two units, 11 invalid. Held stable until granted.
- coin_b  in  2  slot B coin code, same encoding as coin_a.
- coin_a_rdy  out  1  combinational grant for slot A; the coin is consumed on this edge.
- coin_b_rdy  out  1  combinational grant for slot B.
- coin_err  out  1  one-cycle pulse when code 11 is granted; credit unchanged.
- sel  in  2  product index.
- sel_vld  in  1  one-cycle selection strobe.
- sel_nak  out  1  one-cycle pulse when a selection is rejected.
- cancel  in  1  one-cycle refund request.
- restock  in  1  one-cycle strobe that reloads all stock.
- disp_req  out  1  dispense request; held until acknowledged.
- disp_id  out  2  product index being dispensed; stable while disp_req is high.
- disp_ack  in  1  one-cycle acknowledge from the motor driver.
- chg_req  out  1  request to return one coin unit.
- chg_ack  in  1  one-cycle acknowledge for one returned unit.
- credit  out  CW  current credit.
- sold_out  out  NPROD  bit i is high when stock[i] == 0.
- busy  out  1  high in VEND or CHANGE.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, credit = 0, every stock counter = STOCK_INIT, round-robin pointer = A.
  - All registered outputs return to 0 immediately.
  - A reset during VEND or CHANGE aborts the transaction. Credit is lost; nothing is replayed after release.
- States: IDLE, VEND, CHANGE.
- IDLE, evaluated each cycle in this priority order:
  1. cancel with credit > 0: go to CHANGE. cancel with credit == 0 is ignored. cancel beats a simultaneous sel_vld, and no coin is granted that cycle.
  2. sel_vld with credit >= PRICE and stock[sel] > 0:
     - go to VEND, latch disp_id = sel, credit <= credit - PRICE.
     - No coin is granted that cycle.
  3. sel_vld that fails either check: pulse sel_nak next cycle, stay in IDLE; coin granting proceeds normally.
  4. Coin arbitration, at most one grant per cycle:
     - A requester is any slot with a nonzero code that fits: credit + value <= MAX_CREDIT. Code 11 always fits with value 0.
     - One requester: grant it.
     - Two requesters: grant the slot the pointer names, then move the pointer to the other slot. The pointer moves only on a contended grant.
     - Credit updates on the grant edge.
     - A coin that does not fit is held; no grant and no error.
  5. restock: reload every stock counter to STOCK_INIT. Accepted in IDLE only; ignored in VEND and CHANGE.
- VEND:
  - disp_req = 1; coin_a_rdy and coin_b_rdy forced 0; sel_vld and cancel ignored.
  - On disp_ack: stock[disp_id] decrements. Next state is CHANGE if credit > 0, else IDLE. disp_req falls on that edge.
  - No timeout; the controller waits indefinitely for disp_ack.
- CHANGE:
  - chg_req = 1 while in this state; no coin grants.
  - Each chg_ack decrements credit by 1.
  - chg_ack at credit == 1: credit becomes 0, go to IDLE, chg_req falls on the same edge.
- Arithmetic:
  - Credit never exceeds MAX_CREDIT; enforced by coin gating, so no wrap is possible.
  - Stock never decrements below 0; enforced by the selection check.
  - disp_ack, chg_ack and restock outside their valid state are ignored.
- Output timing: sold_out and credit are registered-state views valid every cycle. busy = (state != IDLE).

Test Plan:
1. Reset check: hold rst low, toggle clk 3 cycles → credit 0, disp_req 0, chg_req 0, busy 0, sold_out 0000. Assert rst low mid-VEND → disp_req 0 and credit 0 with no clock edge needed.
2. Full vend with change: coin_a = 10 twice (credit 4), then sel = 1 with sel_vld → next cycle disp_req 1, disp_id 1, credit 1. disp_ack → chg_req 1. chg_ack → credit 0, state IDLE, stock[1] = 3.
3. Contention: from reset, coin_a = 01 and coin_b = 10 in the same cycle → coin_a_rdy first. Next cycle coin_b_rdy, credit 3. Repeat the contended pair → B granted first on the third grant.
4. Ceiling and invalid coin: credit 6, coin_a = 10 → held with no rdy. coin_b = 01 → granted, credit 7. coin_b = 11 → granted, coin_err pulse, credit stays 7.
5. Stock exhaustion: 4 successful vends of product 0 → sold_out[0] = 1. A 5th sel = 0 with credit 3 → sel_nak, credit stays 3. restock in IDLE → sold_out[0] = 0.
6. Refund and priority: credit 5, cancel and sel_vld in the same cycle → CHANGE and no dispense. Exactly 5 chg_ack handshakes to reach credit 0. A coin presented during CHANGE is not granted until IDLE.

Source files
------------

// File: rtl/vend_ctrl.sv
// Transaction controller for a dual-slot coin vending machine: coin arbitration,
// selection checking, dispense handshake and unit-by-unit change return.
module vend_ctrl #(
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 7,
  parameter int CW         = 3,
  parameter int NPROD      = 4,
  parameter int STOCK_INIT = 4,
  parameter int SW         = 3,
  localparam int SELW      = (NPROD > 1) ? $clog2(NPROD) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       coin_a,
  input  logic [1:0]       coin_b,
  output logic             coin_a_rdy,
  output logic             coin_b_rdy,
  output logic             coin_err,
  input  logic [SELW-1:0]  sel,
  input  logic             sel_vld,
  output logic             sel_nak,
  input  logic             cancel,
  input  logic             restock,
  output logic             disp_req,
  output logic [SELW-1:0]  disp_id,
  input  logic             disp_ack,
  output logic             chg_req,
  input  logic             chg_ack,
  output logic [CW-1:0]    credit,
  output logic [NPROD-1:0] sold_out,
  output logic             busy
);

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [CW:0]   MAX_C   = (CW+1)'(MAX_CREDIT);
  localparam logic [SW-1:0] INIT_C  = SW'(STOCK_INIT);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  state_t        state;
  logic [SW-1:0] stock [NPROD];
  logic          rr_b;

  logic [CW:0] sum_a, sum_b;
  logic        fit_a, fit_b, req_a, req_b;
  logic        cancel_go, vend_go, arb_en, grant_inv;

  // Code 11 carries value 0, so it always fits and only raises coin_err.
  function automatic logic [CW:0] coin_val(input logic [1:0] c);
    case (c)
      2'b01:   coin_val = (CW+1)'(1);
      2'b10:   coin_val = (CW+1)'(2);
      default: coin_val = '0;
    endcase
  endfunction

  always_comb begin
    sum_a      = {1'b0, credit} + coin_val(coin_a);
    sum_b      = {1'b0, credit} + coin_val(coin_b);
    fit_a      = (coin_a != 2'b00) && (sum_a <= MAX_C);
    fit_b      = (coin_b != 2'b00) && (sum_b <= MAX_C);
    cancel_go  = cancel && (credit != '0);
    vend_go    = !cancel_go && sel_vld && (credit >= PRICE_C) && (stock[sel] != '0);
    arb_en     = (state == IDLE) && !cancel_go && !vend_go;
    req_a      = arb_en && fit_a;
    req_b      = arb_en && fit_b;
    coin_a_rdy = req_a && (!req_b || !rr_b);
    coin_b_rdy = req_b && (!req_a || rr_b);
    grant_inv  = (coin_a_rdy && coin_a == 2'b11) || (coin_b_rdy && coin_b == 2'b11);
  end

  always_comb begin
    for (int i = 0; i < NPROD; i++) sold_out[i] = (stock[i] == '0);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      credit   <= '0;
      rr_b     <= 1'b0;
      disp_req <= 1'b0;
      disp_id  <= '0;
      chg_req  <= 1'b0;
      sel_nak  <= 1'b0;
      coin_err <= 1'b0;
      for (int i = 0; i < NPROD; i++) stock[i] <= INIT_C;
    end else begin
      sel_nak  <= 1'b0;
      coin_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cancel_go) begin
            state   <= CHANGE;
            chg_req <= 1'b1;
          end else if (vend_go) begin
            state    <= VEND;
            disp_req <= 1'b1;
            disp_id  <= sel;
            credit   <= credit - PRICE_C;
          end else begin
            sel_nak  <= sel_vld;
            coin_err <= grant_inv;
            if (coin_a_rdy)      credit <= sum_a[CW-1:0];
            else if (coin_b_rdy) credit <= sum_b[CW-1:0];
            // The pointer only rotates when both slots actually competed.
            if (req_a && req_b) rr_b <= !rr_b;
          end
          if (restock) begin
            for (int i = 0; i < NPROD; i++) stock[i] <= INIT_C;
          end
        end
        VEND: begin
          if (disp_ack) begin
            stock[disp_id] <= stock[disp_id] - SW'(1);
            disp_req       <= 1'b0;
            if (credit != '0) begin
              state   <= CHANGE;
              chg_req <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        CHANGE: begin
          if (chg_ack) begin
            credit <= credit - CW'(1);
            if (credit == CW'(1)) begin
              state   <= IDLE;
              chg_req <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Table-driven bench for vend_ctrl: each row is one clock of stimulus plus the
// expected grants before the edge and the registered state after it.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin_a, coin_b, sel, disp_id;
  logic       coin_a_rdy, coin_b_rdy, coin_err, sel_vld, sel_nak, cancel, restock;
  logic       disp_req, disp_ack, chg_req, chg_ack, busy;
  logic [2:0] credit;
  logic [3:0] sold_out;

  always #5 clk = ~clk;

  vend_ctrl dut (
    .clk(clk), .rst(rst), .coin_a(coin_a), .coin_b(coin_b),
    .coin_a_rdy(coin_a_rdy), .coin_b_rdy(coin_b_rdy), .coin_err(coin_err),
    .sel(sel), .sel_vld(sel_vld), .sel_nak(sel_nak), .cancel(cancel),
    .restock(restock), .disp_req(disp_req), .disp_id(disp_id),
    .disp_ack(disp_ack), .chg_req(chg_req), .chg_ack(chg_ack),
    .credit(credit), .sold_out(sold_out), .busy(busy)
  );

  typedef struct {
    logic [1:0] ca, cb, sl;
    logic       sv, cn, rs, da, ck;
    logic       ra, rb;
    logic [2:0] cr;
    logic       dr, cq, nk, er;
    logic [1:0] di;
    logic [3:0] so;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input int ca, cb, sl, sv, cn, rs, da, ck,
                              input int ra, rb, cr, dr, cq, nk, er, di, so);
    vec_t v;
    v.ca = 2'(ca); v.cb = 2'(cb); v.sl = 2'(sl);
    v.sv = 1'(sv); v.cn = 1'(cn); v.rs = 1'(rs); v.da = 1'(da); v.ck = 1'(ck);
    v.ra = 1'(ra); v.rb = 1'(rb); v.cr = 3'(cr);
    v.dr = 1'(dr); v.cq = 1'(cq); v.nk = 1'(nk); v.er = 1'(er);
    v.di = 2'(di); v.so = 4'(so);
    return v;
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    coin_a = 2'b00; coin_b = 2'b00; sel = 2'd0; sel_vld = 1'b0; cancel = 1'b0;
    restock = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    if (sb.size() == 0) begin
      cmp($sformatf("v%0d scoreboard empty", idx), 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      cmp($sformatf("v%0d credit", idx),   8'(credit),   8'(e.cr));
      cmp($sformatf("v%0d disp_req", idx), 8'(disp_req), 8'(e.dr));
      cmp($sformatf("v%0d chg_req", idx),  8'(chg_req),  8'(e.cq));
      cmp($sformatf("v%0d busy", idx),     8'(busy),     8'(e.dr | e.cq));
      cmp($sformatf("v%0d sel_nak", idx),  8'(sel_nak),  8'(e.nk));
      cmp($sformatf("v%0d coin_err", idx), 8'(coin_err), 8'(e.er));
      cmp($sformatf("v%0d disp_id", idx),  8'(disp_id),  8'(e.di));
      cmp($sformatf("v%0d sold_out", idx), 8'(sold_out), 8'(e.so));
    end
  endtask

  // Called just after a rising edge: drive, check grants mid-cycle, check state after the next edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    coin_a = v.ca; coin_b = v.cb; sel = v.sl; sel_vld = v.sv; cancel = v.cn;
    restock = v.rs; disp_ack = v.da; chg_ack = v.ck;
    sb.push_back(v);
    @(negedge clk);
    cmp($sformatf("v%0d coin_a_rdy", idx), 8'(coin_a_rdy), 8'(v.ra));
    cmp($sformatf("v%0d coin_b_rdy", idx), 8'(coin_b_rdy), 8'(v.rb));
    @(posedge clk);
    #1;
    checkOutput(idx);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    //                 ca cb sl sv cn rs da ck  ra rb cr dr cq nk er di so
    tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0,  1, 0, 4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0,  0, 1, 3, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0,  0, 1, 5, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 6, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0,  0, 0, 6, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(2, 1, 0, 0, 0, 0, 0, 0,  0, 1, 7, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(2, 3, 0, 0, 0, 0, 0, 0,  0, 1, 7, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 7, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 4, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0,  0, 0, 4, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 3, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 2, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0,  1, 0, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0,  0, 1, 5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2, 1, 1, 0, 0, 0,  0, 0, 5, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 4, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 3, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 2, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0,  1, 0, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 3, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 3, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0));

    rst = 1'b0;
    clearInputs();
    repeat (3) @(posedge clk);
    #1;
    cmp("reset credit",   8'(credit),   8'd0);
    cmp("reset disp_req", 8'(disp_req), 8'd0);
    cmp("reset chg_req",  8'(chg_req),  8'd0);
    cmp("reset busy",     8'(busy),     8'd0);
    cmp("reset sold_out", 8'(sold_out), 8'd0);
    cmp("reset sel_nak",  8'(sel_nak),  8'd0);
    cmp("reset coin_err", 8'(coin_err), 8'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], i);

    // Asynchronous reset in the middle of a dispense must clear it without a clock edge.
    applyStimulus(mk(2, 0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0, 0, 0, 0, 0, 0), 100);
    applyStimulus(mk(2, 0, 0, 0, 0, 0, 0, 0,  1, 0, 4, 0, 0, 0, 0, 0, 0), 101);
    applyStimulus(mk(0, 0, 2, 1, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 2, 0), 102);
    clearInputs();
    #2 rst = 1'b0;
    #1;
    cmp("async rst disp_req", 8'(disp_req), 8'd0);
    cmp("async rst credit",   8'(credit),   8'd0);
    cmp("async rst busy",     8'(busy),     8'd0);
    cmp("async rst disp_id",  8'(disp_id),  8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp("post rst disp_req", 8'(disp_req), 8'd0);
    cmp("post rst chg_req",  8'(chg_req),  8'd0);
    cmp("post rst credit",   8'(credit),   8'd0);
    cmp("post rst busy",     8'(busy),     8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
